// File: rtl/bpm_window_ctrl.sv
// bpm_window_ctrl: debounced beat counter over a timed window, scaled to beats per minute
module bpm_window_ctrl #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int WINDOW_S     = 15,
  parameter int BPM_MULT     = 60 / WINDOW_S,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic       C_100Mhz,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       continuous,
  input  logic       pulse_in,
  output logic       beat,
  output logic       sec_tick,
  output logic [5:0] secs_left,
  output logic       busy,
  output logic [7:0] bpm,
  output logic       bpm_valid,
  output logic       sat
);
  localparam int PW = $clog2(CLK_HZ + 1);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [PW-1:0] P_TC   = PW'(CLK_HZ - 1);
  localparam logic [DW-1:0] D_TC   = DW'(DEBOUNCE_CYC - 1);
  localparam logic [5:0]    P_WIN  = 6'(WINDOW_S);
  localparam logic [15:0]   P_MULT = 16'(BPM_MULT);
  typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_t;
  state_t          r_state;
  logic            r_s1, r_s2, r_filt;
  logic [DW-1:0]   r_db;
  logic [PW-1:0]   r_presc;
  logic [7:0]      r_cnt;
  logic [7:0]      w_cnt_nxt;
  logic [15:0]     w_prod;
  logic [PW-1:0]   w_presc_nxt;
  logic            w_wrap, w_arm, w_dif;
  assign w_dif       = r_s2 != r_filt;
  assign w_cnt_nxt   = (beat && r_cnt != 8'hff) ? r_cnt + 8'd1 : r_cnt;
  assign w_prod      = {8'd0, w_cnt_nxt} * P_MULT;
  assign w_wrap      = r_presc == P_TC;
  assign w_presc_nxt = w_wrap ? '0 : r_presc + 1'b1;
  assign w_arm       = !stop && ((r_state == IDLE && start) || (r_state == DONE && continuous));
  // Synchronize the sensor, accept a new level only after it holds for the debounce time, flag rising edges
  always_ff @(posedge C_100Mhz or posedge reset) begin
    if (reset) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_filt <= 1'b0;
      r_db   <= '0;
      beat   <= 1'b0;
    end else begin
      r_s1   <= pulse_in;
      r_s2   <= r_s1;
      r_db   <= (w_dif && r_db != D_TC) ? r_db + 1'b1 : '0;
      r_filt <= (w_dif && r_db == D_TC) ? r_s2 : r_filt;
      beat   <= w_dif && r_s2 && r_db == D_TC;
    end
  end
  // Window sequencer: arm, count seconds and beats, then publish the scaled result for one cycle
  always_ff @(posedge C_100Mhz or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_presc   <= '0;
      r_cnt     <= '0;
      sec_tick  <= 1'b0;
      secs_left <= '0;
      busy      <= 1'b0;
      bpm       <= '0;
      bpm_valid <= 1'b0;
      sat       <= 1'b0;
    end else begin
      bpm_valid <= 1'b0;
      if (w_arm) begin
        r_state   <= MEASURE;
        r_presc   <= '0;
        r_cnt     <= '0;
        busy      <= 1'b1;
        secs_left <= P_WIN;
        sec_tick  <= P_TC == '0;
      end else if (r_state == MEASURE && !stop && !(w_wrap && secs_left == 6'd1)) begin
        r_presc   <= w_presc_nxt;
        r_cnt     <= w_cnt_nxt;
        sec_tick  <= w_presc_nxt == P_TC;
        secs_left <= w_wrap ? secs_left - 6'd1 : secs_left;
      end else begin
        r_state   <= (r_state == MEASURE && !stop) ? DONE : IDLE;
        r_presc   <= '0;
        r_cnt     <= w_cnt_nxt;
        busy      <= 1'b0;
        sec_tick  <= 1'b0;
        secs_left <= '0;
        bpm       <= (r_state == MEASURE && !stop) ? ((w_prod > 16'd255) ? 8'hff : w_prod[7:0]) : bpm;
        sat       <= (r_state == MEASURE && !stop) ? (w_prod > 16'd255) : sat;
        bpm_valid <= r_state == MEASURE && !stop;
      end
    end
  end
endmodule

// File: tb/tb_bpm_window_ctrl.sv
// tb_bpm_window_ctrl: directed scenarios checked against a window-arithmetic model plus literal expectations
module tb_bpm_window_ctrl;
  localparam int CLK = 100, WIN = 15, DEB = 4, MULT = 60 / WIN;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, continuous = 1'b0, pulse_in = 1'b0;
  logic beat, sec_tick, busy, bpm_valid, sat;
  logic [5:0] secs_left;
  logic [7:0] bpm;
  int tests = 0, fails = 0;
  logic cmp_en = 1'b0;
  logic m_s1, m_s2, m_filt, m_beat, m_active, m_done, m_sat, m_go;
  int m_run, m_t, m_cnt, m_bpm, m_prod;
  bpm_window_ctrl #(.CLK_HZ(CLK), .WINDOW_S(WIN), .DEBOUNCE_CYC(DEB)) dut (
    .C_100Mhz(clk), .reset(reset), .start(start), .stop(stop), .continuous(continuous),
    .pulse_in(pulse_in), .beat(beat), .sec_tick(sec_tick), .secs_left(secs_left),
    .busy(busy), .bpm(bpm), .bpm_valid(bpm_valid), .sat(sat)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input int a, input int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", n, $time, a, e);
    end
  endtask
  // Model: window position is elapsed cycles since arming; seconds and completion follow by division
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      {m_s1, m_s2, m_filt, m_beat, m_active, m_done, m_sat} = '0;
      m_run = 0; m_t = 0; m_cnt = 0; m_bpm = 0;
    end else begin
      if (m_active && m_beat) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      m_beat = 1'b0;
      if (m_s2 != m_filt) begin
        m_run++;
        if (m_run == DEB) begin
          m_filt = m_s2;
          m_run = 0;
          m_beat = m_filt;
        end
      end else m_run = 0;
      m_s2 = m_s1;
      m_s1 = pulse_in;
      if (m_active) begin
        if (stop) m_active = 1'b0;
        else if (m_t == WIN * CLK - 1) begin
          m_active = 1'b0;
          m_done = 1'b1;
          m_prod = m_cnt * MULT;
          m_bpm = (m_prod > 255) ? 255 : m_prod;
          m_sat = m_prod > 255;
        end else m_t++;
      end else begin
        m_go = m_done ? (continuous && !stop) : (start && !stop);
        m_done = 1'b0;
        if (m_go) begin
          m_active = 1'b1;
          m_t = 0;
          m_cnt = 0;
        end
      end
    end
  end
  // Compare every DUT output against the model shortly after each active edge
  always @(posedge clk) begin
    #1;
    if (cmp_en && !reset) begin
      chk("beat", beat, m_beat);
      chk("sec_tick", sec_tick, m_active && ((m_t + 1) % CLK == 0));
      chk("secs_left", secs_left, m_active ? WIN - m_t / CLK : 0);
      chk("busy", busy, m_active);
      chk("bpm", bpm, m_bpm);
      chk("bpm_valid", bpm_valid, m_done);
      chk("sat", sat, m_sat);
    end
  end
  function automatic logic pat(input int mode, input int i);
    return mode == 0 ? (i >= 10 && i < 10 + 18 * 60 && (i - 10) % 60 < 20) :
           mode == 1 ? (i >= 10 && i < 10 + 10 * 60 && (i - 10) % 60 < 20) :
           mode == 2 ? ((i < 1450 && i % 30 < 3) || (i >= 5 && i < 5 + 5 * 300 && (i - 5) % 300 < 20)) :
           mode == 3 ? (i >= 10 && i < 10 + 70 * 20 && (i - 10) % 20 < 10) :
           mode == 4 ? ((i >= 10 && i < 10 + 18 * 60 && (i - 10) % 60 < 20) || (i >= 1495 && i < 1515) ||
                        (i >= 1520 && i < 1520 + 25 * 50 && (i - 1520) % 50 < 20)) :
                       ((i >= 10 && i < 10 + 10 * 60 && (i - 10) % 60 < 20) ||
                        (i >= 910 && i < 910 + 18 * 60 && (i - 910) % 60 < 20));
  endfunction
  task automatic run(input int mode, input int len);
    int nbeat = 0, nval = 0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      nbeat += int'(beat);
      nval += int'(bpm_valid);
      if (mode == 0 && i == 0) chk("nom_idle_busy", busy, 0);
      if (mode == 0 && i == 1) begin chk("nom_busy1", busy, 1); chk("nom_secs1", secs_left, 15); end
      if (mode == 0 && i == 100) begin chk("nom_tick100", sec_tick, 1); chk("nom_secs100", secs_left, 15); end
      if (mode == 0 && i == 101) begin chk("nom_tick101", sec_tick, 0); chk("nom_secs101", secs_left, 14); end
      if (mode == 0 && i == 1500) begin chk("nom_tick1500", sec_tick, 1); chk("nom_secs1500", secs_left, 1); end
      if (mode == 0 && i == 1501) begin
        chk("nom_valid", bpm_valid, 1); chk("nom_bpm", bpm, 72); chk("nom_sat", sat, 0);
        chk("nom_busy_fall", busy, 0); chk("nom_secs_done", secs_left, 0);
      end
      if (mode == 1 && i == 700) chk("abort_busy700", busy, 1);
      if (mode == 1 && i == 701) begin chk("abort_busy701", busy, 0); chk("abort_secs", secs_left, 0); end
      if (mode == 2 && i == 1501) begin chk("deb_valid", bpm_valid, 1); chk("deb_bpm", bpm, 20); end
      if (mode == 3 && i == 1501) begin
        chk("sat_valid", bpm_valid, 1); chk("sat_bpm", bpm, 255); chk("sat_flag", sat, 1);
      end
      if (mode == 4 && i == 1501) begin
        chk("cont_valid1", bpm_valid, 1); chk("cont_bpm1", bpm, 72); chk("cont_edge_beat", beat, 1);
      end
      if (mode == 4 && i == 1502) begin chk("cont_rearm", busy, 1); chk("cont_secs", secs_left, 15); end
      if (mode == 4 && i == 3002) begin chk("cont_valid2", bpm_valid, 1); chk("cont_bpm2", bpm, 100); end
      if (mode == 4 && i == 3003) chk("cont_idle", busy, 0);
      if (mode == 5 && i == 2401) begin chk("rst_valid", bpm_valid, 1); chk("rst_bpm", bpm, 72); end
      pulse_in = pat(mode, i);
      start = i == 0 || (mode == 5 && i == 900);
      stop = mode == 1 && i == 700;
      continuous = mode == 4 && i < 2000;
      reset = mode == 5 && i == 800;
      if (reset) begin
        #1;
        chk("arst_busy", busy, 0); chk("arst_secs", secs_left, 0); chk("arst_bpm", bpm, 0);
        chk("arst_tick", sec_tick, 0); chk("arst_beat", beat, 0); chk("arst_valid", bpm_valid, 0);
        chk("arst_sat", sat, 0);
      end
    end
    @(negedge clk);
    {pulse_in, start, stop, continuous, reset} = '0;
    case (mode)
      0: begin chk("nom_beats", nbeat, 18); chk("nom_nvalid", nval, 1); end
      1: begin chk("abort_nvalid", nval, 0); chk("abort_bpm_kept", bpm, 72); chk("abort_beats", nbeat, 10); end
      2: chk("deb_beats", nbeat, 5);
      3: chk("sat_beats", nbeat, 70);
      4: begin chk("cont_beats", nbeat, 44); chk("cont_nvalid", nval, 2); end
      default: chk("rst_nvalid", nval, 1);
    endcase
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0); chk("reset_bpm", bpm, 0); chk("reset_secs", secs_left, 0);
    chk("reset_valid", bpm_valid, 0); chk("reset_sat", sat, 0);
    reset = 1'b0;
    cmp_en = 1'b1;
    repeat (5) @(negedge clk);
    run(0, 1510);
    run(1, 720);
    run(2, 1510);
    run(3, 1510);
    run(4, 3010);
    run(5, 2410);
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
